// File: rtl/sar_adc_pkg.sv
// Shared definitions for the SAR ADC conversion sequencer.
//   ADC_WIDTH_DEF : default SAR_ADC result width
//   seq_state_t   : sequencer FSM states
//   acc_width()   : accumulator width needed to sum 2^osr_log2 samples
package sar_adc_pkg;

   localparam int ADC_WIDTH_DEF = 8;

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      CONV
   } seq_state_t;

   // Summing 2^osr_log2 values of adc_width bits needs osr_log2 extra bits.
   function automatic int acc_width(input int adc_width, input int osr_log2);
      return adc_width + osr_log2;
   endfunction

endpackage

// File: rtl/sar_adc_seq_if.sv
// Valid/ready result bus between the sequencer and the system-side consumer.
//   res_valid : averaged result available (producer -> consumer)
//   res_ready : consumer accepts the result (consumer -> producer)
//   res_data  : averaged result (producer -> consumer)
// master = result producer (sequencer), slave = consumer.
interface sar_adc_seq_if
   import sar_adc_pkg::*;
#(
   parameter int W = ADC_WIDTH_DEF
) ();

   logic         res_valid;
   logic         res_ready;
   logic [W-1:0] res_data;

   modport master (output res_valid, output res_data, input res_ready);
   modport slave  (input res_valid, input res_data, output res_ready);

endinterface

// File: rtl/sar_adc_result_reg.sv
// Output holding register for averaged results with overrun detection.
//   clk, rst_n : clock, asynchronous active-low reset
//   load       : a new averaged result is offered this cycle
//   load_data  : the offered result
//   overrun    : one-cycle pulse, offered result dropped because the
//                previous one was still pending
//   res        : valid/ready result bus (master side)
module sar_adc_result_reg
   import sar_adc_pkg::*;
#(
   parameter int W = ADC_WIDTH_DEF
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         load,
   input  logic [W-1:0] load_data,
   output logic         overrun,
   sar_adc_seq_if.master res
);

   logic         valid_q, valid_d;
   logic [W-1:0] data_q, data_d;
   logic         overrun_q, overrun_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q   <= 1'b0;
         data_q    <= '0;
         overrun_q <= 1'b0;
      end else begin
         valid_q   <= valid_d;
         data_q    <= data_d;
         overrun_q <= overrun_d;
      end
   end

   // A load in the same cycle as a handshake replaces the accepted result,
   // so the slot counts as free whenever the consumer is taking it now.
   always_comb begin
      valid_d   = valid_q;
      data_d    = data_q;
      overrun_d = 1'b0;
      if (valid_q && res.res_ready) begin
         valid_d = 1'b0;
      end
      if (load) begin
         if (!valid_q || res.res_ready) begin
            valid_d = 1'b1;
            data_d  = load_data;
         end else begin
            overrun_d = 1'b1;
         end
      end
   end

   assign res.res_valid = valid_q;
   assign res.res_data  = data_q;
   assign overrun       = overrun_q;

endmodule

// File: rtl/sar_adc_seq.sv
// Conversion sequencer and oversampling averager for a SAR ADC.
//   clk, rst_n  : clock, asynchronous active-low reset
//   en          : sequencer enable
//   period      : sample period in clk cycles (0 behaves as 1)
//   start       : one-cycle conversion request to the ADC
//   eoc         : ADC end-of-conversion (informational only)
//   den, Dout   : ADC data-valid strobe and conversion result
//   res         : valid/ready averaged-result bus (master side)
//   overrun     : pulse, finished average dropped (previous still pending)
//   missed_tick : pulse, period tick arrived during a conversion
//   timeout_err : pulse, conversion aborted after TIMEOUT cycles without den
module sar_adc_seq
   import sar_adc_pkg::*;
#(
   parameter int ADC_WIDTH = ADC_WIDTH_DEF,
   parameter int OSR_LOG2  = 2,
   parameter int PERIOD_W  = 16,
   parameter int TIMEOUT   = 32
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 en,
   input  logic [PERIOD_W-1:0]  period,
   output logic                 start,
   input  logic                 eoc,
   input  logic                 den,
   input  logic [ADC_WIDTH-1:0] Dout,
   sar_adc_seq_if.master        res,
   output logic                 overrun,
   output logic                 missed_tick,
   output logic                 timeout_err
);

   localparam int ACC_W = acc_width(ADC_WIDTH, OSR_LOG2);
   localparam int CNT_W = OSR_LOG2 + 1;
   localparam int TO_W  = $clog2(TIMEOUT + 1);
   localparam logic [CNT_W-1:0] BATCH   = CNT_W'(2 ** OSR_LOG2);
   localparam logic [TO_W-1:0]  TO_LAST = TO_W'(TIMEOUT - 1);

   seq_state_t          state_q, state_d;
   logic [PERIOD_W-1:0] cnt_q, cnt_d;
   logic [ACC_W-1:0]    acc_q, acc_d;
   logic [CNT_W-1:0]    count_q, count_d;
   logic [TO_W-1:0]     to_q, to_d;
   logic                discard_q, discard_d;
   logic                start_q, start_d;
   logic                missed_q, missed_d;
   logic                timeout_q, timeout_d;

   logic                tick;
   logic                to_expire;
   logic                abort;
   logic                batch_done;
   logic                load;
   logic [PERIOD_W-1:0] reload;
   logic [ACC_W-1:0]    acc_next;
   logic [CNT_W-1:0]    count_inc;
   logic [ADC_WIDTH-1:0] result;
   logic                eoc_unused;

   assign eoc_unused = eoc;

   // The period counter only runs outside IDLE, so it is still 0 when WAIT
   // is entered and the first tick lands in that very cycle.
   assign tick       = en && (state_q != IDLE) && (cnt_q == '0);
   assign reload     = (period == '0) ? '0 : period - PERIOD_W'(1);
   assign to_expire  = (state_q == CONV) && (to_q == TO_LAST);
   // A disable seen at any point of the conversion throws the batch away.
   assign abort      = !en || discard_q;
   assign acc_next   = acc_q + ACC_W'(Dout);
   assign count_inc  = count_q + CNT_W'(1);
   assign batch_done = (count_inc == BATCH);
   assign result     = ADC_WIDTH'(acc_next >> OSR_LOG2);

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         acc_q     <= '0;
         count_q   <= '0;
         to_q      <= '0;
         discard_q <= 1'b0;
         start_q   <= 1'b0;
         missed_q  <= 1'b0;
         timeout_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         acc_q     <= acc_d;
         count_q   <= count_d;
         to_q      <= to_d;
         discard_q <= discard_d;
         start_q   <= start_d;
         missed_q  <= missed_d;
         timeout_q <= timeout_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: if (en) state_d = WAIT;
         WAIT: begin
            if (!en) begin
               state_d = IDLE;
            end else if (tick) begin
               state_d = CONV;
            end
         end
         CONV: begin
            if (den || to_expire) begin
               state_d = abort ? IDLE : WAIT;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Output and datapath logic
   always_comb begin
      start_d   = 1'b0;
      missed_d  = 1'b0;
      timeout_d = 1'b0;
      load      = 1'b0;
      acc_d     = acc_q;
      count_d   = count_q;
      to_d      = to_q;
      discard_d = discard_q;

      // A new period value is only sampled on reload.
      if (!en || (state_q == IDLE)) begin
         cnt_d = '0;
      end else if (cnt_q == '0) begin
         cnt_d = reload;
      end else begin
         cnt_d = cnt_q - PERIOD_W'(1);
      end

      case (state_q)
         IDLE: begin
            acc_d     = '0;
            count_d   = '0;
            discard_d = 1'b0;
         end
         WAIT: begin
            if (!en) begin
               acc_d   = '0;
               count_d = '0;
            end else if (tick) begin
               start_d   = 1'b1;
               to_d      = '0;
               discard_d = 1'b0;
            end
         end
         CONV: begin
            to_d     = to_q + TO_W'(1);
            missed_d = tick;
            if (!en) discard_d = 1'b1;
            if (den) begin
               if (abort) begin
                  acc_d   = '0;
                  count_d = '0;
               end else if (batch_done) begin
                  load    = 1'b1;
                  acc_d   = '0;
                  count_d = '0;
               end else begin
                  acc_d   = acc_next;
                  count_d = count_inc;
               end
            end else if (to_expire) begin
               timeout_d = 1'b1;
               acc_d     = '0;
               count_d   = '0;
            end
         end
         default: begin
            acc_d   = '0;
            count_d = '0;
         end
      endcase
   end

   sar_adc_result_reg #(
      .W (ADC_WIDTH)
   ) u_result_reg (
      .clk       (clk),
      .rst_n     (rst_n),
      .load      (load),
      .load_data (result),
      .overrun   (overrun),
      .res       (res)
   );

   assign start       = start_q;
   assign missed_tick = missed_q;
   assign timeout_err = timeout_q;

endmodule

// File: doc/sar_adc_seq.md
Name: sar_adc_seq

Overview:
Conversion sequencer and oversampling averager for SAR_ADC.
- Drives SAR_ADC `start` at a programmable sample period.
- Captures `Dout` when `den` is high.
- Accumulates 2^OSR_LOG2 conversions and emits the truncated mean on a valid/ready result interface.
- Flags conversion timeouts, skipped ticks and dropped results.
- Sits between SAR_ADC and the system-side consumer (FIFO/bus bridge).

Parameters:
- ADC_WIDTH, 8, SAR_ADC result width.
- OSR_LOG2, 2, log2 of conversions averaged per result (0 = no averaging).
- PERIOD_W, 16, width of the sample-period input.
- TIMEOUT, 32, max cycles from `start` to `den` before abort (must be ≥ ADC_WIDTH+2).

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- en  input  1  sequencer enable.
- period  input  PERIOD_W  sample period in clk cycles; 0 treated as 1.
- start  output  1  one-cycle conversion request to SAR_ADC.
- eoc  input  1  SAR_ADC end-of-conversion; informational, not required for capture.
- den  input  1  SAR_ADC data-valid strobe.
- Dout  input  ADC_WIDTH  SAR_ADC conversion result.
- res_valid  output  1  averaged result available.
- res_ready  input  1  consumer accepts result.
- res_data  output  ADC_WIDTH  averaged result.
- overrun  output  1  one-cycle pulse: new result dropped because res_valid still high.
- missed_tick  output  1  one-cycle pulse: period tick arrived while a conversion was in flight.
- timeout_err  output  1  one-cycle pulse: conversion aborted, no `den` within TIMEOUT cycles.

Behaviour:
- Clock/reset: one clock `clk`; `rst_n` is asynchronous, active-low.
- Reset values: all outputs 0, accumulator 0, sample count 0, period counter 0, FSM IDLE.
- Registered outputs: all outputs are registered.
- Period counter:
  - While en=1: counts down; a tick occurs at 0, then reloads max(period,1)-1.
  - While en=0: held at 0.
  - A `period` change takes effect at the next reload.
- FSM states: IDLE, WAIT, CONV.
- IDLE:
  - en=1 → WAIT. The first tick occurs in the cycle WAIT is entered, because the counter is at 0.
- WAIT:
  - On tick: start=1 for exactly the next cycle, timeout counter cleared, → CONV.
  - en=0 → IDLE, discarding any partial batch (acc and count cleared).
- CONV:
  - On den=1: acc += Dout (acc width ADC_WIDTH+OSR_LOG2, cannot overflow) and count++.
    - If count reaches 2^OSR_LOG2: result = acc_next >> OSR_LOG2 (truncation); clear acc and count.
    - In all cases → WAIT.
  - If TIMEOUT cycles elapse with no den: timeout_err pulse, discard whole batch, → WAIT.
  - Tick while in CONV: missed_tick pulse; the tick is not queued.
  - en=0 in CONV: current conversion completes or times out first; then batch discarded, → IDLE.
- den outside CONV is ignored.
- Result output:
  - res_valid/res_data are loaded the cycle after the completing den.
  - res_valid holds and res_data is stable until res_valid&res_ready.
  - On a handshake, res_valid drops next cycle unless a new result loads in that same cycle, in which case it stays high with the new data.
  - New result while res_valid=1 and res_ready=0: result dropped, res_data unchanged, overrun pulse.
- Minimum period:
  - Throughput is limited by SAR_ADC latency.
  - period shorter than conversion time yields missed_tick every skipped tick; data is still correct.
- Reset mid-operation: returns immediately to reset values; a partially driven start pulse is cut.

Decomposition:
- Package sar_adc_pkg holds:
  - ADC_WIDTH default.
  - Enum seq_state_t {IDLE, WAIT, CONV}.
  - Function acc_width(ADC_WIDTH, OSR_LOG2).
- One sub-module is natural: sar_adc_result_reg, the valid/ready output holding register with overrun detection.
- Period counter and accumulator stay inline.

Test Plan:
- OSR_LOG2=2, period=20, model returns 0x10,0x20,0x30,0x41, res_ready=1 → one start per 20 cycles; res_data=0x28 (0xA1>>2), res_valid high 1 cycle, no error pulses.
- OSR_LOG2=2, four conversions of 0xFF → res_data=0xFF; accumulator reaches 0x3FC without overflow. Four conversions of 0x00 → res_data=0x00.
- res_ready=0 across two complete batches (first average 0x28, second 0x50) → res_data stays 0x28, overrun pulses once; raising res_ready gives one handshake, then res_valid drops.
- Model never asserts den after start, TIMEOUT=32 → timeout_err pulse 32 cycles after start, count cleared; next batch of four 0x40 gives res_data=0x40.
- period=3 with a 12-cycle conversion → missed_tick pulses on each skipped tick; start never asserted while in CONV; averages still correct.
- Assert rst_n=0 mid-CONV with count=2, then release → all outputs 0; the next full batch averages only new samples; en=0 mid-batch → IDLE, no result emitted.
